// File: rtl/data_bus_bridge_if.sv
// rtl/data_bus_bridge_if.sv - Wishbone B4 classic signal bundle between the bridge and the bus fabric
interface data_bus_bridge_if;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [29:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
        output i_wb_dat, i_wb_ack, i_wb_err
    );
endinterface

// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - multi-cycle bridge from the core data port to a Wishbone B4 classic bus
module data_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    input  logic [31:0]             i_req_addr,
    input  logic [31:0]             i_req_wdata,
    input  logic [1:0]              i_req_width,
    input  logic                    i_req_we,
    input  logic                    i_req_zeroextend,
    output logic                    o_stall,
    output logic [31:0]             o_rdata,
    output logic                    o_rdata_valid,
    output logic                    o_bus_err,
    output logic                    o_misaligned,
    data_bus_bridge_if.master       wb
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("data_bus_bridge: TIMEOUT_CYCLES must be 1..65535");
    end

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [1:0]  lat_width;
    logic [1:0]  lat_off;
    logic        lat_we;
    logic        lat_zext;
    logic        accept;
    logic        misaligned_req;
    logic        bus_done;
    logic [3:0]  req_sel;
    logic [31:0] req_wdat;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign accept   = i_req_valid && (state != ST_BUS);
    assign o_stall  = accept || (state == ST_BUS);
    assign bus_done = wb.i_wb_ack || wb.i_wb_err || (cnt == LAST_CNT);

    always_comb begin
        misaligned_req = 1'b0;
        case (i_req_width)
            2'b00:   misaligned_req = 1'b0;
            2'b01:   misaligned_req = i_req_addr[0];
            2'b10:   misaligned_req = |i_req_addr[1:0];
            default: misaligned_req = 1'b1;
        endcase
    end

    // Narrow stores are replicated across the word so any lane the slave picks holds the data.
    always_comb begin
        req_sel  = 4'b1111;
        req_wdat = i_req_wdata;
        case (i_req_width)
            2'b00: begin
                req_sel  = 4'b0001 << i_req_addr[1:0];
                req_wdat = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                req_sel  = i_req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdat = {2{i_req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_byte = wb.i_wb_dat[7:0];
        case (lat_off)
            2'd0:    rd_byte = wb.i_wb_dat[7:0];
            2'd1:    rd_byte = wb.i_wb_dat[15:8];
            2'd2:    rd_byte = wb.i_wb_dat[23:16];
            default: rd_byte = wb.i_wb_dat[31:24];
        endcase
        rd_half   = lat_off[1] ? wb.i_wb_dat[31:16] : wb.i_wb_dat[15:0];
        load_data = wb.i_wb_dat;
        case (lat_width)
            2'b00:   load_data = {{24{rd_byte[7] & ~lat_zext}}, rd_byte};
            2'b01:   load_data = {{16{rd_half[15] & ~lat_zext}}, rd_half};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = misaligned_req ? ST_DONE : ST_BUS;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus_done) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response flags default low every cycle so they pulse for exactly the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            cnt           <= 16'd0;
            lat_width     <= 2'b00;
            lat_off       <= 2'b00;
            lat_we        <= 1'b0;
            lat_zext      <= 1'b0;
            o_rdata       <= 32'd0;
            o_rdata_valid <= 1'b0;
            o_bus_err     <= 1'b0;
            o_misaligned  <= 1'b0;
            wb.o_wb_cyc   <= 1'b0;
            wb.o_wb_stb   <= 1'b0;
            wb.o_wb_we    <= 1'b0;
            wb.o_wb_adr   <= 30'd0;
            wb.o_wb_sel   <= 4'd0;
            wb.o_wb_dat   <= 32'd0;
        end else begin
            o_rdata       <= 32'd0;
            o_rdata_valid <= 1'b0;
            o_bus_err     <= 1'b0;
            o_misaligned  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (misaligned_req) begin
                            o_rdata_valid <= 1'b1;
                            o_misaligned  <= 1'b1;
                        end else begin
                            cnt         <= 16'd0;
                            lat_width   <= i_req_width;
                            lat_off     <= i_req_addr[1:0];
                            lat_we      <= i_req_we;
                            lat_zext    <= i_req_zeroextend;
                            wb.o_wb_cyc <= 1'b1;
                            wb.o_wb_stb <= 1'b1;
                            wb.o_wb_we  <= i_req_we;
                            wb.o_wb_adr <= i_req_addr[31:2];
                            wb.o_wb_sel <= req_sel;
                            wb.o_wb_dat <= req_wdat;
                        end
                    end
                end
                ST_BUS: begin
                    cnt <= cnt + 16'd1;
                    if (bus_done) begin
                        wb.o_wb_cyc   <= 1'b0;
                        wb.o_wb_stb   <= 1'b0;
                        wb.o_wb_we    <= 1'b0;
                        o_rdata_valid <= 1'b1;
                        if (wb.i_wb_ack) begin
                            o_rdata <= lat_we ? 32'd0 : load_data;
                        end else begin
                            o_bus_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - randomized scoreboard bench for data_bus_bridge
module tb_data_bus_bridge;
    localparam int TIMEOUT = 4;

    logic        i_clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [1:0]  i_req_width;
    logic        i_req_we;
    logic        i_req_zeroextend;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_valid;
    logic        o_bus_err;
    logic        o_misaligned;

    data_bus_bridge_if wb ();

    data_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk            (i_clk),
        .rst              (rst),
        .i_req_valid      (i_req_valid),
        .i_req_addr       (i_req_addr),
        .i_req_wdata      (i_req_wdata),
        .i_req_width      (i_req_width),
        .i_req_we         (i_req_we),
        .i_req_zeroextend (i_req_zeroextend),
        .o_stall          (o_stall),
        .o_rdata          (o_rdata),
        .o_rdata_valid    (o_rdata_valid),
        .o_bus_err        (o_bus_err),
        .o_misaligned     (o_misaligned),
        .wb               (wb)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        bus_err;
        logic        misaligned;
    } resp_t;

    typedef struct {
        logic [29:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        int          len;
    } bus_t;

    // mode: 0 ack, 1 err, 2 ack+err together, 3 never respond
    typedef struct {
        int          mode;
        int          waits;
        logic [31:0] rdata;
    } plan_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return 1 << w;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] w);
        return (w == 2'b11) || ((addr % nbytes(w)) != 0);
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] w, input logic [1:0] off);
        int s;
        s = ((1 << nbytes(w)) - 1) << off;
        return s[3:0];
    endfunction

    function automatic logic [31:0] model_wdat(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'b00) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (w == 2'b01) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] w,
                                               input logic [1:0] off, input logic zext);
        logic [31:0] v;
        logic [31:0] mask;
        int          bits;
        v    = d >> (8 * off);
        bits = 8 * nbytes(w);
        if (bits < 32) begin
            mask = (32'd1 << bits) - 32'd1;
            v    = v & mask;
            if (!zext && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // Bus slave: follows the plan queue, random data on every non-ack cycle.
    bit    s_active = 1'b0;
    int    s_cycles;
    plan_t s_cur;
    always @(negedge i_clk) begin
        wb.i_wb_ack = 1'b0;
        wb.i_wb_err = 1'b0;
        wb.i_wb_dat = $urandom;
        if (wb.o_wb_cyc === 1'b1 && wb.o_wb_stb === 1'b1) begin
            if (!s_active) begin
                s_active = 1'b1;
                s_cycles = 0;
                if (plan_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL slave_plan unexpected bus cycle at %0t", $time);
                    s_cur.mode  = 3;
                    s_cur.waits = 0;
                    s_cur.rdata = 32'd0;
                end else begin
                    s_cur = plan_q.pop_front();
                end
            end
            s_cycles++;
            if (s_cycles == s_cur.waits + 1) begin
                if (s_cur.mode == 0 || s_cur.mode == 2) begin
                    wb.i_wb_ack = 1'b1;
                    wb.i_wb_dat = s_cur.rdata;
                end
                if (s_cur.mode == 1 || s_cur.mode == 2) wb.i_wb_err = 1'b1;
            end
        end else begin
            s_active = 1'b0;
        end
    end

    bit   b_active = 1'b0;
    int   b_len;
    bus_t b_exp;
    always @(negedge i_clk) begin
        if (wb.o_wb_cyc === 1'b1) begin
            if (!b_active) begin
                b_active = 1'b1;
                b_len    = 0;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected cyc asserted with nothing expected at %0t", $time);
                    b_exp.len = -1;
                end else begin
                    b_exp = bus_q.pop_front();
                    check("wb_adr", {2'b00, wb.o_wb_adr}, {2'b00, b_exp.adr});
                    check("wb_sel", {28'd0, wb.o_wb_sel}, {28'd0, b_exp.sel});
                    check("wb_we", {31'd0, wb.o_wb_we}, {31'd0, b_exp.we});
                    check("wb_stb", {31'd0, wb.o_wb_stb}, 32'd1);
                    if (b_exp.we) check("wb_dat", wb.o_wb_dat, b_exp.dat);
                end
            end
            b_len++;
        end else if (b_active) begin
            b_active = 1'b0;
            if (b_exp.len >= 0) check("cyc_len", b_len, b_exp.len);
        end
    end

    resp_t r_exp;
    always @(negedge i_clk) begin
        if (o_rdata_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected rdata_valid with nothing expected at %0t", $time);
            end else begin
                r_exp = resp_q.pop_front();
                check("rdata", o_rdata, r_exp.rdata);
                check("bus_err", {31'd0, o_bus_err}, {31'd0, r_exp.bus_err});
                check("misaligned", {31'd0, o_misaligned}, {31'd0, r_exp.misaligned});
            end
        end
    end

    // Called mid-cycle while the DUT is IDLE or DONE; returns just after the DONE negedge.
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] w,
                         input logic we, input logic zext, input int mode, input int waits,
                         input logic [31:0] rd, input bit abort_rst);
        resp_t r;
        bus_t  b;
        plan_t p;
        int    lat;
        int    n;
        if (is_misaligned(addr, w)) begin
            r.rdata      = 32'd0;
            r.bus_err    = 1'b0;
            r.misaligned = 1'b1;
            lat          = 1;
        end else begin
            p.mode  = mode;
            p.waits = waits;
            p.rdata = rd;
            plan_q.push_back(p);
            b.adr = addr[31:2];
            b.sel = model_sel(w, addr[1:0]);
            b.we  = we;
            b.dat = model_wdat(w, wdata);
            r.misaligned = 1'b0;
            if (mode == 3) begin
                b.len     = TIMEOUT;
                r.rdata   = 32'd0;
                r.bus_err = 1'b1;
                lat       = TIMEOUT + 1;
            end else begin
                b.len     = waits + 1;
                r.bus_err = (mode == 1);
                r.rdata   = (mode == 1 || we) ? 32'd0 : model_load(rd, w, addr[1:0], zext);
                lat       = waits + 2;
            end
            if (abort_rst) b.len = 2;
            bus_q.push_back(b);
        end
        if (!abort_rst) resp_q.push_back(r);

        i_req_valid      = 1'b1;
        i_req_addr       = addr;
        i_req_wdata      = wdata;
        i_req_width      = w;
        i_req_we         = we;
        i_req_zeroextend = zext;
        #1;
        check("stall_accept", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        i_req_wdata = $urandom;
        i_req_width = 2'($urandom_range(0, 3));
        i_req_we    = 1'($urandom_range(0, 1));

        if (abort_rst) begin
            @(posedge i_clk);
            #1;
            rst = 1'b1;
            @(posedge i_clk);
            #1;
            rst = 1'b0;
            check("abort_cyc", {31'd0, wb.o_wb_cyc}, 32'd0);
            check("abort_stb", {31'd0, wb.o_wb_stb}, 32'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge i_clk);
                check("abort_no_resp", {31'd0, o_rdata_valid}, 32'd0);
            end
        end else begin
            n = 0;
            do begin
                @(negedge i_clk);
                n++;
                if (o_rdata_valid !== 1'b1) check("stall_busy", {31'd0, o_stall}, 32'd1);
            end while (o_rdata_valid !== 1'b1 && n < 40);
            check("latency", n, lat);
            check("stall_done", {31'd0, o_stall}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          r;
        int          mode;
        logic [31:0] a;
        rst              = 1'b1;
        i_req_valid      = 1'b0;
        i_req_addr       = 32'd0;
        i_req_wdata      = 32'd0;
        i_req_width      = 2'b00;
        i_req_we         = 1'b0;
        i_req_zeroextend = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        rst = 1'b0;
        @(negedge i_clk);
        check("rst_cyc", {31'd0, wb.o_wb_cyc}, 32'd0);
        check("rst_stb", {31'd0, wb.o_wb_stb}, 32'd0);
        check("rst_sel", {28'd0, wb.o_wb_sel}, 32'd0);
        check("rst_adr", {2'd0, wb.o_wb_adr}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_valid", {31'd0, o_rdata_valid}, 32'd0);
        check("rst_flags", {30'd0, o_bus_err, o_misaligned}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);

        issue(32'h2000_0004, 32'd0, 2'b10, 1'b0, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        @(negedge i_clk);
        issue(32'h1000_0003, 32'd0, 2'b00, 1'b0, 1'b0, 0, 1, 32'h80FF_0000, 1'b0);
        issue(32'h1000_0003, 32'd0, 2'b00, 1'b0, 1'b1, 0, 0, 32'h80FF_0000, 1'b0);
        issue(32'h1000_0002, 32'd0, 2'b01, 1'b0, 1'b0, 0, 2, 32'h80FF_0000, 1'b0);
        issue(32'h3000_0002, 32'h1234_ABCD, 2'b01, 1'b1, 1'b0, 0, 3, 32'h5555_AAAA, 1'b0);
        issue(32'h0000_0006, 32'd0, 2'b10, 1'b0, 1'b0, 0, 0, 32'd0, 1'b0);
        issue(32'h0000_0004, 32'd0, 2'b11, 1'b0, 1'b0, 0, 0, 32'd0, 1'b0);
        issue(32'h4000_0000, 32'd0, 2'b10, 1'b0, 1'b0, 3, 0, 32'd0, 1'b0);
        issue(32'h4000_0008, 32'd0, 2'b10, 1'b0, 1'b0, 1, 1, 32'h1111_2222, 1'b0);
        issue(32'h4000_0001, 32'd0, 2'b00, 1'b0, 1'b1, 2, 0, 32'h0000_A500, 1'b0);
        @(negedge i_clk);
        issue(32'h5000_0010, 32'd0, 2'b10, 1'b0, 1'b0, 3, 0, 32'd0, 1'b1);
        issue(32'h6000_0000, 32'd0, 2'b10, 1'b0, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0);
        issue(32'h6000_0002, 32'd0, 2'b01, 1'b0, 1'b1, 0, 0, 32'hCAFE_F00D, 1'b0);

        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            r    = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 0;
            a    = $urandom;
            issue(a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), mode, $urandom_range(0, 3), $urandom, 1'b0);
        end

        repeat (4) @(negedge i_clk);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("plan_q_drained", plan_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Multi-cycle bridge between the CPU core's data port and a Wishbone B4 classic bus.
- Replaces the single-cycle data path into memory_controller so slow peripherals can insert wait states.
- Accepts one load/store request at a time and generates byte lanes and write-data replication.
- Stalls the core until the bus acknowledges, then returns sign- or zero-extended read data.
- Flags misaligned accesses, bus errors and timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack/err before aborting with an error; must be 1..65535.

Ports:
- i_clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  load/store request present
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-aligned
- i_req_width  in  2  00 byte, 01 half, 10 word, 11 invalid
- i_req_we  in  1  1 = store
- i_req_zeroextend  in  1  1 = zero-extend load, 0 = sign-extend
- o_stall  out  1  hold request/pipeline
- o_rdata  out  32  extended load data
- o_rdata_valid  out  1  one-cycle response strobe
- o_bus_err  out  1  response was ack-less (err or timeout)
- o_misaligned  out  1  response was a rejected misaligned access
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone controls
- o_wb_adr  out  30  word address (addr[31:2])
- o_wb_sel  out  4  byte lane enables
- o_wb_dat  out  32  write data
- i_wb_dat  in  32  read data
- i_wb_ack  in  1  acknowledge
- i_wb_err  in  1  error

Behaviour:
- Reset: state IDLE; all outputs 0; counter 0; any in-flight cycle abandoned (cyc/stb low the cycle after rst sampled), no response generated.
- States: IDLE, BUS, DONE. A request is accepted when state is IDLE or DONE and i_req_valid=1.
- o_stall is combinational: 1 when a request is being accepted (cycle T), and 1 throughout BUS. It is 0 in DONE unless a new request is accepted that cycle. It is 0 in IDLE with no request.
- Accept, aligned: latch addr, width, we, zeroextend and lane offset addr[1:0]. Next state BUS. All Wishbone outputs are registered and valid from T+1.
- Accept, misaligned:
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or width=11.
  - No bus cycle. Next state DONE with o_misaligned=1, o_rdata_valid=1, o_rdata=0.
- BUS:
  - cyc=stb=1 held constant until termination.
  - Counter increments each BUS cycle.
  - i_wb_ack takes priority over i_wb_err. ack may arrive in the first BUS cycle.
  - On ack: next state DONE, o_rdata_valid=1, o_bus_err=0, cyc/stb low.
  - On err or counter==TIMEOUT_CYCLES-1 without ack: next DONE, o_bus_err=1, o_rdata=0.
- DONE: response outputs valid for exactly one cycle. Without a new request, next state IDLE and all response flags clear.
- Latency: minimum 2 cycles from acceptance to o_rdata_valid (request at T, ack at T+1, response at T+2). Back-to-back requests from DONE have no idle bubble.
- Lane select (sel), off = addr[1:0]:
  - byte: 1<<off
  - half: off=0 → 0011, off=2 → 1100
  - word: 1111
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load extract: byte i_wb_dat[8*off+:8], half i_wb_dat[16*off[1]+:16], extended per zeroextend. i_wb_dat is sampled only on the ack edge. Stores return o_rdata=0.
- Request inputs are ignored while in BUS.

Test Plan:
- Word load addr 0x2000_0004, ack on first BUS cycle, i_wb_dat=0xDEADBEEF → adr=0x0800_0001, sel=1111, we=0; o_rdata=0xDEADBEEF with valid at T+2; o_stall high T..T+1.
- Signed byte load addr 0x...03, i_wb_dat=0x80FF_0000, zeroextend=0 → sel=1000, o_rdata=0xFFFF_FF80. Same with zeroextend=1 → 0x0000_0080. Half at off 2 signed → 0xFFFF_80FF.
- Half store addr 0x...02, wdata=0x1234_ABCD, ack after 3 wait cycles → o_wb_dat=0xABCD_ABCD, sel=1100, we=1, cyc held 4 cycles; response o_rdata=0, bus_err=0.
- Word load addr 0x...06 → no cyc asserted; next cycle o_misaligned=1, o_rdata_valid=1; width=11 gives the same result.
- TIMEOUT_CYCLES=4, no ack → cyc high exactly 4 cycles, then o_bus_err=1, o_rdata=0. Separately, i_wb_err and i_wb_ack asserted together → ack wins, bus_err=0.
- rst asserted in 2nd BUS cycle → cyc/stb low next cycle, no o_rdata_valid. Also two back-to-back loads with the second presented in DONE → second cyc starts the cycle after DONE.
